// File: rtl/clock_pkg.sv
// Shared types and constants for the alarm/clock datapath: FSM state encoding and BCD helpers.
package clock_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        RING   = 2'd1,
        SNOOZE = 2'd2
    } state_e;

    localparam logic [7:0] BCD_ZERO     = 8'h00;
    localparam int         SECS_PER_MIN = 60;

endpackage

// File: rtl/alarm_ring_ctrl_if.sv
// Timekeeping and alarm-setting bus feeding the ring controller.
interface alarm_ring_ctrl_if #(
    parameter int N_ALARMS = 4
);
    logic                  sec_tick;
    logic [7:0]            hour1;
    logic [7:0]            min1;
    logic [7:0]            sec1;
    logic [8*N_ALARMS-1:0] ahour;
    logic [8*N_ALARMS-1:0] amin;
    logic [N_ALARMS-1:0]   al_en;
    logic                  chime_en;

    modport master (output sec_tick, hour1, min1, sec1, ahour, amin, al_en, chime_en);
    modport slave  (input  sec_tick, hour1, min1, sec1, ahour, amin, al_en, chime_en);
endinterface

// File: rtl/alarm_match.sv
// Per-channel alarm comparators with lowest-index priority; purely combinational.
// Only fires on the sec_tick cycle that lands on second 00, so each match occurs once per minute.
module alarm_match
    import clock_pkg::*;
#(
    parameter int N_ALARMS = 4,
    parameter int ID_W     = 2
) (
    input  logic                  sec_tick,
    input  logic [7:0]            hour1,
    input  logic [7:0]            min1,
    input  logic [7:0]            sec1,
    input  logic [8*N_ALARMS-1:0] ahour,
    input  logic [8*N_ALARMS-1:0] amin,
    input  logic [N_ALARMS-1:0]   al_en,
    output logic                  hit,
    output logic [ID_W-1:0]       hit_id
);

    // Descending scan so the lowest matching channel is the last one written.
    always_comb begin
        hit    = 1'b0;
        hit_id = '0;
        for (int i = N_ALARMS - 1; i >= 0; i--) begin
            if (sec_tick && sec1 == BCD_ZERO && al_en[i] &&
                hour1 == ahour[8*i +: 8] && min1 == amin[8*i +: 8]) begin
                hit    = 1'b1;
                hit_id = ID_W'(i);
            end
        end
    end

endmodule

// File: rtl/alarm_ring_ctrl.sv
// Multi-channel alarm ring/snooze FSM with hourly chime, gating the buzzer tones onto alert.
// Latency: a match on the sec_tick cycle rings from the next clk edge; no backpressure, buttons are single-cycle pulses.
module alarm_ring_ctrl
    import clock_pkg::*;
#(
    parameter int N_ALARMS   = 4,
    parameter int RING_SECS  = 60,
    parameter int SNOOZE_MIN = 5,
    parameter int MAX_SNOOZE = 3,
    parameter int CHIME_SECS = 2,
    localparam int ID_W      = (N_ALARMS > 1) ? $clog2(N_ALARMS) : 1
) (
    input  logic                  clk,
    input  logic                  rst,
    alarm_ring_ctrl_if.slave      tm,
    input  logic                  stop_btn,
    input  logic                  snooze_btn,
    input  logic                  clk_1KHZ,
    input  logic                  clk_100HZ,
    output logic                  alert,
    output logic                  ringing,
    output logic                  snoozing,
    output logic [ID_W-1:0]       ring_id
);

    localparam int SU_W      = (MAX_SNOOZE > 0) ? $clog2(MAX_SNOOZE + 1) : 1;
    localparam int SNZ_LIMIT = SNOOZE_MIN * SECS_PER_MIN;

    localparam logic [1:0] S_IDLE   = IDLE;
    localparam logic [1:0] S_RING   = RING;
    localparam logic [1:0] S_SNOOZE = SNOOZE;

    logic [1:0]      state, state_nxt;
    logic [7:0]      ring_cnt, ring_cnt_nxt;
    logic [9:0]      snz_cnt, snz_cnt_nxt;
    logic [SU_W-1:0] snz_used, snz_used_nxt;
    logic [ID_W-1:0] ring_id_nxt;
    logic            ring_gate, chime_gate;
    logic            hit;
    logic [ID_W-1:0] hit_id;

    alarm_match #(
        .N_ALARMS (N_ALARMS),
        .ID_W     (ID_W)
    ) u_match (
        .sec_tick (tm.sec_tick),
        .hour1    (tm.hour1),
        .min1     (tm.min1),
        .sec1     (tm.sec1),
        .ahour    (tm.ahour),
        .amin     (tm.amin),
        .al_en    (tm.al_en),
        .hit      (hit),
        .hit_id   (hit_id)
    );

    // Buttons take priority over the second counters; stop beats snooze.
    always_comb begin
        state_nxt    = state;
        ring_cnt_nxt = ring_cnt;
        snz_cnt_nxt  = snz_cnt;
        snz_used_nxt = snz_used;
        ring_id_nxt  = ring_id;
        case (state)
            S_IDLE: begin
                if (hit) begin
                    state_nxt    = S_RING;
                    ring_id_nxt  = hit_id;
                    ring_cnt_nxt = '0;
                    snz_used_nxt = '0;
                end
            end
            S_RING: begin
                if (stop_btn) begin
                    state_nxt = S_IDLE;
                end else if (snooze_btn) begin
                    if (snz_used < SU_W'(MAX_SNOOZE)) begin
                        state_nxt    = S_SNOOZE;
                        snz_used_nxt = snz_used + 1'b1;
                        snz_cnt_nxt  = '0;
                    end else begin
                        state_nxt = S_IDLE;
                    end
                end else if (tm.sec_tick) begin
                    ring_cnt_nxt = ring_cnt + 1'b1;
                    if (ring_cnt_nxt == 8'(RING_SECS))
                        state_nxt = S_IDLE;
                end
            end
            S_SNOOZE: begin
                if (stop_btn) begin
                    state_nxt = S_IDLE;
                end else if (hit) begin
                    state_nxt    = S_RING;
                    ring_id_nxt  = hit_id;
                    ring_cnt_nxt = '0;
                    snz_used_nxt = '0;
                end else if (tm.sec_tick) begin
                    snz_cnt_nxt = snz_cnt + 1'b1;
                    if (snz_cnt_nxt == 10'(SNZ_LIMIT)) begin
                        state_nxt    = S_RING;
                        ring_cnt_nxt = '0;
                    end
                end
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= S_IDLE;
            ring_cnt   <= '0;
            snz_cnt    <= '0;
            snz_used   <= '0;
            ring_id    <= '0;
            ring_gate  <= 1'b0;
            chime_gate <= 1'b0;
        end else begin
            state      <= state_nxt;
            ring_cnt   <= ring_cnt_nxt;
            snz_cnt    <= snz_cnt_nxt;
            snz_used   <= snz_used_nxt;
            ring_id    <= ring_id_nxt;
            ring_gate  <= (state_nxt == S_RING);
            // A ringing alarm suppresses the chime.
            chime_gate <= tm.chime_en && tm.min1 == BCD_ZERO && tm.sec1[7:4] == 4'd0 &&
                          tm.sec1[3:0] < 4'(CHIME_SECS) && state_nxt != S_RING;
        end
    end

    assign ringing  = (state == S_RING);
    assign snoozing = (state == S_SNOOZE);
    assign alert    = (ring_gate ? clk_100HZ : 1'b1) & (chime_gate ? clk_1KHZ : 1'b1);

endmodule

// File: tb/tb_alarm_ring_ctrl.sv
// Directed bench for alarm_ring_ctrl: match, timeout, snooze limit, stop priority, chime, preemption, reset.
module tb_alarm_ring_ctrl;

    logic       clk = 1'b0;
    logic       rst, stop_btn, snooze_btn, clk_1KHZ, clk_100HZ;
    logic       alert, ringing, snoozing;
    logic [1:0] ring_id;
    int         checks = 0;
    int         errors = 0;
    int         tsec   = 0;

    always #5 clk = ~clk;

    alarm_ring_ctrl_if #(.N_ALARMS(4)) tif ();

    alarm_ring_ctrl #(
        .N_ALARMS(4), .RING_SECS(60), .SNOOZE_MIN(5), .MAX_SNOOZE(3), .CHIME_SECS(2)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .tm         (tif),
        .stop_btn   (stop_btn),
        .snooze_btn (snooze_btn),
        .clk_1KHZ   (clk_1KHZ),
        .clk_100HZ  (clk_100HZ),
        .alert      (alert),
        .ringing    (ringing),
        .snoozing   (snoozing),
        .ring_id    (ring_id)
    );

    function automatic logic [7:0] bcd(input int v);
        return {4'(v / 10), 4'(v % 10)};
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic show_time();
        tif.hour1 = bcd(tsec / 3600);
        tif.min1  = bcd((tsec / 60) % 60);
        tif.sec1  = bcd(tsec % 60);
    endtask

    task automatic set_time(input int h, input int m, input int s);
        tsec = h * 3600 + m * 60 + s;
        show_time();
    endtask

    // Advance one second: sec_tick on the first edge, idle second edge.
    task automatic tick();
        tsec = (tsec + 1) % 86400;
        show_time();
        tif.sec_tick = 1'b1;
        step();
        tif.sec_tick = 1'b0;
        step();
    endtask

    task automatic ring_at(input int h, input int m);
        set_time(h, m, 0);
        tsec = (tsec + 86399) % 86400;
        show_time();
        tick();
    endtask

    task automatic press_snooze();
        snooze_btn = 1'b1;
        step();
        snooze_btn = 1'b0;
    endtask

    task automatic press_stop();
        stop_btn = 1'b1;
        step();
        stop_btn = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        step();
        step();
        rst = 1'b0;
        checks++; if (ringing !== 1'b0)  begin errors++; $display("FAIL reset_ringing: got %b want 0", ringing); end
        checks++; if (snoozing !== 1'b0) begin errors++; $display("FAIL reset_snoozing: got %b want 0", snoozing); end
        checks++; if (ring_id !== 2'd0)  begin errors++; $display("FAIL reset_ring_id: got %0d want 0", ring_id); end
        checks++; if (alert !== 1'b1)    begin errors++; $display("FAIL reset_alert: got %b want 1", alert); end
    endtask

    task automatic test_match();
        tif.al_en = 4'b0110;
        tif.ahour = {4{8'h07}};
        tif.amin  = {4{8'h30}};
        set_time(7, 29, 58);
        tick();
        checks++; if (ringing !== 1'b0) begin errors++; $display("FAIL pre_match_ringing: got %b want 0", ringing); end
        tsec++;
        show_time();
        tif.sec_tick = 1'b1;
        step();
        tif.sec_tick = 1'b0;
        checks++; if (ringing !== 1'b1) begin errors++; $display("FAIL match_ringing: got %b want 1", ringing); end
        checks++; if (ring_id !== 2'd1) begin errors++; $display("FAIL match_ring_id: got %0d want 1", ring_id); end
        checks++; if (alert !== 1'b0)   begin errors++; $display("FAIL match_alert_low: got %b want 0", alert); end
        clk_100HZ = 1'b1;
        #1;
        checks++; if (alert !== 1'b1)   begin errors++; $display("FAIL match_alert_high: got %b want 1", alert); end
        clk_100HZ = 1'b0;
    endtask

    task automatic test_timeout();
        repeat (59) tick();
        checks++; if (ringing !== 1'b1) begin errors++; $display("FAIL timeout_59: got %b want 1", ringing); end
        tsec++;
        show_time();
        tif.sec_tick = 1'b1;
        step();
        tif.sec_tick = 1'b0;
        checks++; if (ringing !== 1'b0) begin errors++; $display("FAIL timeout_60: got %b want 0", ringing); end
        checks++; if (alert !== 1'b1)   begin errors++; $display("FAIL timeout_alert: got %b want 1", alert); end
        step();
    endtask

    task automatic test_snooze();
        ring_at(7, 30);
        checks++; if (ringing !== 1'b1) begin errors++; $display("FAIL snz_start: got %b want 1", ringing); end
        for (int k = 1; k <= 3; k++) begin
            press_snooze();
            checks++; if (snoozing !== 1'b1 || ringing !== 1'b0) begin errors++; $display("FAIL snz_enter_%0d: snoozing=%b ringing=%b want 1/0", k, snoozing, ringing); end
            checks++; if (alert !== 1'b1) begin errors++; $display("FAIL snz_alert_%0d: got %b want 1", k, alert); end
            if (k == 1) begin
                press_snooze();
                checks++; if (snoozing !== 1'b1) begin errors++; $display("FAIL snz_ignored: got %b want 1", snoozing); end
            end
            repeat (299) tick();
            checks++; if (snoozing !== 1'b1) begin errors++; $display("FAIL snz_299_%0d: got %b want 1", k, snoozing); end
            tick();
            checks++; if (ringing !== 1'b1 || ring_id !== 2'd1) begin errors++; $display("FAIL snz_rering_%0d: ringing=%b id=%0d want 1/1", k, ringing, ring_id); end
        end
        press_snooze();
        checks++; if (ringing !== 1'b0 || snoozing !== 1'b0) begin errors++; $display("FAIL snz_limit: ringing=%b snoozing=%b want 0/0", ringing, snoozing); end
    endtask

    task automatic test_stop_priority();
        ring_at(7, 30);
        stop_btn   = 1'b1;
        snooze_btn = 1'b1;
        step();
        stop_btn   = 1'b0;
        snooze_btn = 1'b0;
        checks++; if (ringing !== 1'b0 || snoozing !== 1'b0) begin errors++; $display("FAIL stop_wins: ringing=%b snoozing=%b want 0/0", ringing, snoozing); end
        press_snooze();
        checks++; if (ringing !== 1'b0 || snoozing !== 1'b0) begin errors++; $display("FAIL idle_buttons: ringing=%b snoozing=%b want 0/0", ringing, snoozing); end
        ring_at(7, 30);
        press_snooze();
        press_stop();
        checks++; if (snoozing !== 1'b0 || ringing !== 1'b0) begin errors++; $display("FAIL stop_in_snooze: ringing=%b snoozing=%b want 0/0", ringing, snoozing); end
    endtask

    task automatic test_preempt();
        tif.amin[23:16] = 8'h31;
        ring_at(7, 30);
        press_snooze();
        repeat (59) tick();
        checks++; if (snoozing !== 1'b1) begin errors++; $display("FAIL preempt_wait: got %b want 1", snoozing); end
        tick();
        checks++; if (ringing !== 1'b1 || ring_id !== 2'd2) begin errors++; $display("FAIL preempt_ring: ringing=%b id=%0d want 1/2", ringing, ring_id); end
        press_stop();
        tif.amin[23:16] = 8'h30;
    endtask

    task automatic test_chime();
        tif.al_en    = 4'b0000;
        tif.chime_en = 1'b1;
        set_time(11, 59, 58);
        tick();
        checks++; if (alert !== 1'b1) begin errors++; $display("FAIL chime_before: got %b want 1", alert); end
        tick();
        checks++; if (alert !== 1'b0) begin errors++; $display("FAIL chime_sec00_low: got %b want 0", alert); end
        clk_1KHZ = 1'b1;
        #1;
        checks++; if (alert !== 1'b1) begin errors++; $display("FAIL chime_sec00_high: got %b want 1", alert); end
        clk_1KHZ = 1'b0;
        tick();
        checks++; if (alert !== 1'b0) begin errors++; $display("FAIL chime_sec01: got %b want 0", alert); end
        tick();
        checks++; if (alert !== 1'b1) begin errors++; $display("FAIL chime_sec02: got %b want 1", alert); end
        tif.al_en        = 4'b0010;
        tif.ahour[15:8]  = 8'h12;
        tif.amin[15:8]   = 8'h00;
        ring_at(12, 0);
        clk_100HZ = 1'b1;
        #1;
        checks++; if (ringing !== 1'b1 || alert !== 1'b1) begin errors++; $display("FAIL chime_suppressed: ringing=%b alert=%b want 1/1", ringing, alert); end
        clk_100HZ = 1'b0;
        #1;
        checks++; if (alert !== 1'b0) begin errors++; $display("FAIL chime_alarm_tone: got %b want 0", alert); end
        press_stop();
        tif.chime_en    = 1'b0;
        tif.al_en       = 4'b0110;
        tif.ahour[15:8] = 8'h07;
        tif.amin[15:8]  = 8'h30;
    endtask

    task automatic test_reset_snooze();
        ring_at(7, 30);
        press_snooze();
        repeat (300) tick();
        checks++; if (ringing !== 1'b1) begin errors++; $display("FAIL rsnz_rering: got %b want 1", ringing); end
        press_snooze();
        checks++; if (snoozing !== 1'b1) begin errors++; $display("FAIL rsnz_second: got %b want 1", snoozing); end
        rst = 1'b1;
        step();
        rst = 1'b0;
        checks++; if (snoozing !== 1'b0 || ringing !== 1'b0 || alert !== 1'b1) begin errors++; $display("FAIL rsnz_reset: snoozing=%b ringing=%b alert=%b want 0/0/1", snoozing, ringing, alert); end
        ring_at(7, 30);
        for (int k = 1; k <= 3; k++) begin
            press_snooze();
            checks++; if (snoozing !== 1'b1) begin errors++; $display("FAIL rsnz_full_%0d: got %b want 1", k, snoozing); end
            repeat (300) tick();
        end
        press_snooze();
        checks++; if (ringing !== 1'b0 || snoozing !== 1'b0) begin errors++; $display("FAIL rsnz_limit: ringing=%b snoozing=%b want 0/0", ringing, snoozing); end
    endtask

    initial begin
        rst          = 1'b1;
        stop_btn     = 1'b0;
        snooze_btn   = 1'b0;
        clk_1KHZ     = 1'b0;
        clk_100HZ    = 1'b0;
        tif.sec_tick = 1'b0;
        tif.chime_en = 1'b0;
        tif.al_en    = '0;
        tif.ahour    = '0;
        tif.amin     = '0;
        set_time(0, 0, 30);
        test_reset();
        test_match();
        test_timeout();
        test_snooze();
        test_stop_priority();
        test_preempt();
        test_chime();
        test_reset_snooze();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/alarm_ring_ctrl.md
Name: alarm_ring_ctrl

Overview:
- Parametrised successor to the single-alarm ring logic.
- Supports N_ALARMS independent alarm channels, each with its own enable.
- Adds ring timeout, a snooze state machine with a snooze limit, and an hourly chime of configurable length.
- Sits between the BCD timekeeping/alarm-setting registers and the buzzer driver; emits the same idle-high gated-tone alert signal.

Parameters:
N_ALARMS, 4, number of alarm channels (1..8)
RING_SECS, 60, seconds an alarm rings before auto-stop (1..255)
SNOOZE_MIN, 5, snooze interval in minutes (1..15)
MAX_SNOOZE, 3, snoozes allowed per alarm event; the next snooze press acts as stop
CHIME_SECS, 2, hourly chime length in seconds (1..9)

Ports:
clk  in  1  system clock
rst  in  1  reset, synchronous, active-high
sec_tick  in  1  one-clk pulse per second, aligned with sec update
hour1  in  8  current hour, BCD
min1  in  8  current minute, BCD
sec1  in  8  current second, BCD
ahour  in  8*N_ALARMS  alarm hours, BCD, channel i at [8i+7:8i]
amin  in  8*N_ALARMS  alarm minutes, BCD, same packing
al_en  in  N_ALARMS  per-channel alarm enable
chime_en  in  1  hourly chime enable
stop_btn  in  1  debounced one-clk pulse
snooze_btn  in  1  debounced one-clk pulse
clk_1KHZ  in  1  chime tone
clk_100HZ  in  1  alarm tone
alert  out  1  buzzer drive, idle 1, tone-gated when active
ringing  out  1  FSM in RING
snoozing  out  1  FSM in SNOOZE
ring_id  out  max(1,clog2(N_ALARMS))  channel that triggered the current event

Behaviour:
- Reset (sync, rst=1 at posedge clk):
  - state=IDLE; all counters 0.
  - ringing=0, snoozing=0, ring_id=0, internal ring/chime gates=0, so alert=1.
- Match detection:
  - Channel i matches when al_en[i], hour1==ahour[i], min1==amin[i], sec1==8'h00, and sec_tick=1.
  - Raw 8-bit BCD equality only; no BCD validation.
  - Lowest matching index wins.
  - Fires once per minute; there is no level retrigger.
- FSM states and transitions:
  - IDLE → RING on match. Latch ring_id; ring_cnt=0, snz_used=0.
  - RING:
    - ring_cnt increments on sec_tick; when it reaches RING_SECS → IDLE.
    - stop_btn → IDLE.
    - snooze_btn:
      - snz_used<MAX_SNOOZE → SNOOZE; snz_used+1, snz_cnt=0.
      - otherwise → IDLE.
    - stop_btn and snooze_btn in the same cycle: stop wins.
    - New matches while in RING are ignored.
  - SNOOZE:
    - snz_cnt increments on sec_tick; when it reaches SNOOZE_MIN*60 → RING with the same ring_id, ring_cnt=0.
    - stop_btn → IDLE.
    - snooze_btn ignored.
    - A new match preempts: → RING with the new ring_id; snz_used=0.
- Ring gate: registered, =1 exactly while state==RING.
- Chime gate:
  - Registered; =1 when chime_en, min1==8'h00, sec1[7:4]==0, sec1[3:0]<CHIME_SECS, and next state != RING.
  - The alarm suppresses the chime.
- Output: alert = (ring_gate ? clk_100HZ : 1) & (chime_gate ? clk_1KHZ : 1).
  - This is the only combinational path; tone inputs are not re-registered.
- Latency: a match on the sec_tick cycle gives ringing=1 and the alert gate on the next clk edge.
- Buttons pulsed in IDLE have no effect.
- rst asserted mid-RING or mid-SNOOZE: immediate return to IDLE, alert=1 on the next edge.
- Disabling al_en[ring_id] during RING/SNOOZE does not cancel the event; stop or timeout is required.
- Counter widths:
  - ring_cnt 8 bit.
  - snz_cnt 10 bit (max 900).
  - snz_used clog2(MAX_SNOOZE+1).

Decomposition:
- Shared package clock_pkg:
  - FSM state enum (IDLE, RING, SNOOZE).
  - BCD constants BCD_ZERO=8'h00 and SECS_PER_MIN=60.
- Sub-module alarm_match: N_ALARMS comparators plus priority encoder.
  - Outputs hit and hit_id; purely combinational.
  - Instantiated once.

Test Plan:
- N=4, al_en=4'b0110, ahour[1]=ahour[2]=8'h07, amin=8'h30, time steps to 07:30:00 with sec_tick → ringing=1, ring_id=1, alert follows clk_100HZ next cycle.
- Ringing, no buttons, 60 sec_ticks → ringing=0 on the 60th tick edge, alert=1.
- Ringing, snooze_btn → snoozing=1, alert=1. After 300 sec_ticks → ringing=1, same ring_id. Repeat 3×; 4th snooze_btn → IDLE.
- stop_btn and snooze_btn in the same cycle while ringing → IDLE, snoozing=0.
- chime_en=1, time 12:00:00 → alert follows clk_1KHZ for sec 00–01, alert=1 at 12:00:02. Same chime with an alarm at 12:00 → only clk_100HZ tone, no 1 kHz.
- rst pulse while in SNOOZE with snz_used=2 → IDLE. The next alarm match allows the full 3 snoozes.
